// File: rtl/mux_lectura_picoblaze_pkg.sv
// Shared definitions for the PicoBlaze read-side mux.
// Holds the read port map and the interrupt FSM state encoding.
package pkg_puertos_picoblaze;

    localparam int unsigned PUERTO_W = 8;

    // PicoBlaze INPUT port addresses
    localparam logic [PUERTO_W-1:0] P_EVENTOS = 8'h02;
    localparam logic [PUERTO_W-1:0] P_SWITCH  = 8'h04;
    localparam logic [PUERTO_W-1:0] P_RTC     = 8'h08;
    localparam logic [PUERTO_W-1:0] P_ESTADO  = 8'h10;

    typedef enum logic [1:0] {
        INT_IDLE = 2'd0,
        INT_REQ  = 2'd1,
        INT_WAIT = 2'd2
    } estado_int_t;

endpackage

// File: rtl/mux_lectura_picoblaze_if.sv
// PicoBlaze port/interrupt bus as seen by read-side peripherals.
//   port_id/rd_10/interrupt_ack : driven by the processor (master)
//   in_port/interrupt           : driven by the peripheral (slave)
interface mux_lectura_picoblaze_if;
    import pkg_puertos_picoblaze::*;

    logic [PUERTO_W-1:0] port_id;
    logic                rd_10;
    logic [PUERTO_W-1:0] in_port;
    logic                interrupt;
    logic                interrupt_ack;

    modport master (
        output port_id, rd_10, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, rd_10, interrupt_ack,
        output in_port, interrupt
    );

endinterface

// File: rtl/mux_lectura_picoblaze_antirrebote_flanco.sv
// Button conditioner: 2-flop synchroniser, debounce counter and rising-edge pulse.
//   reloj, resetM : clock, async active-low reset
//   boton         : raw asynchronous button, active-high
//   pulso_c       : one-cycle pulse, high in the cycle before the debounced level rises
module antirrebote_flanco #(
    parameter int unsigned DEB_CICLOS = 16,
    parameter int unsigned DEB_W      = 5
) (
    input  logic reloj,
    input  logic resetM,
    input  logic boton,
    output logic pulso_c
);

    logic [1:0]       sinc;
    logic             nivel;
    logic [DEB_W-1:0] cuenta;
    logic             cambio_c;
    logic             fin_c;

    // Synced level disagrees with the accepted level; fin_c marks the last stable cycle
    assign cambio_c = sinc[1] != nivel;
    assign fin_c    = cambio_c && (cuenta == DEB_W'(DEB_CICLOS - 1));

    // Pulse is combinational so the event register sets on the same edge the level toggles
    assign pulso_c  = fin_c && !nivel;

    // Synchroniser and debounce state
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            sinc   <= 2'b00;
            nivel  <= 1'b0;
            cuenta <= '0;
        end else begin
            sinc <= {sinc[0], boton};
            if (!cambio_c) begin
                cuenta <= '0;
            end else if (fin_c) begin
                cuenta <= '0;
                nivel  <= ~nivel;
            end else begin
                cuenta <= cuenta + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_lectura_picoblaze.sv
// Read-side mux for PicoBlaze INPUT instructions.
//   reloj, resetM          : clock, async active-low reset
//   pb (slave)             : port_id, rd_10, interrupt_ack in; in_port, interrupt out (registered)
//   bot_arriba/abajo/izq/der : raw buttons, debounced into sticky read-to-clear events
//   sw_prog, sw_formato    : raw slide switches, synchronised only
//   dato_rtc, dato_rtc_valid : RTC read bus and its one-cycle strobe
module mux_lectura_picoblaze
    import pkg_puertos_picoblaze::*;
#(
    parameter int unsigned DEB_CICLOS = 16,
    parameter int unsigned DEB_W      = 5,
    parameter bit          INT_EN     = 1'b1
) (
    input  logic                    reloj,
    input  logic                    resetM,
    mux_lectura_picoblaze_if.slave  pb,
    input  logic                    bot_arriba,
    input  logic                    bot_abajo,
    input  logic                    bot_izq,
    input  logic                    bot_der,
    input  logic                    sw_prog,
    input  logic                    sw_formato,
    input  logic [PUERTO_W-1:0]     dato_rtc,
    input  logic                    dato_rtc_valid
);

    localparam int unsigned N_BOT = 4;

    logic [N_BOT-1:0]    botones;
    logic [N_BOT-1:0]    pulso_c;
    logic [N_BOT-1:0]    ev;
    logic [1:0]          sw_s0;
    logic [1:0]          sw_s1;
    logic [PUERTO_W-1:0] rtc_reg;
    logic                dato_nuevo;
    logic                overflow;
    logic                borra_ev_c;
    logic                borra_rtc_c;
    logic                pend_c;
    logic [PUERTO_W-1:0] dato_c;
    estado_int_t         estado;

    // Bit order matches ev = {arriba, abajo, izq, der}
    assign botones = {bot_arriba, bot_abajo, bot_izq, bot_der};

    for (genvar i = 0; i < N_BOT; i++) begin : g_boton
        antirrebote_flanco #(
            .DEB_CICLOS (DEB_CICLOS),
            .DEB_W      (DEB_W)
        ) u_antirrebote (
            .reloj   (reloj),
            .resetM  (resetM),
            .boton   (botones[i]),
            .pulso_c (pulso_c[i])
        );
    end

    assign borra_ev_c  = pb.rd_10 && (pb.port_id == P_EVENTOS);
    assign borra_rtc_c = pb.rd_10 && (pb.port_id == P_ESTADO);
    assign pend_c      = (ev != '0) || dato_nuevo;

    // Event flags, switch synchroniser and RTC capture; sets win over read-clears
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            ev         <= '0;
            sw_s0      <= 2'b00;
            sw_s1      <= 2'b00;
            rtc_reg    <= '0;
            dato_nuevo <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            ev    <= (borra_ev_c ? '0 : ev) | pulso_c;
            sw_s0 <= {sw_formato, sw_prog};
            sw_s1 <= sw_s0;
            if (dato_rtc_valid) begin
                rtc_reg    <= dato_rtc;
                dato_nuevo <= 1'b1;
                overflow   <= borra_rtc_c ? 1'b0 : (overflow || dato_nuevo);
            end else if (borra_rtc_c) begin
                dato_nuevo <= 1'b0;
                overflow   <= 1'b0;
            end
        end
    end

    // Read map decode
    always_comb begin
        dato_c = '0;
        case (pb.port_id)
            P_EVENTOS: dato_c = {4'b0000, ev};
            P_SWITCH:  dato_c = {6'b000000, sw_s1};
            P_RTC:     dato_c = rtc_reg;
            P_ESTADO:  dato_c = {6'b000000, overflow, dato_nuevo};
            default:   dato_c = '0;
        endcase
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            pb.in_port <= '0;
        end else begin
            pb.in_port <= dato_c;
        end
    end

    // Interrupt request/ack FSM; no re-raise until every pending flag has been cleared
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            estado       <= INT_IDLE;
            pb.interrupt <= 1'b0;
        end else begin
            case (estado)
                INT_IDLE: begin
                    if (INT_EN && pend_c) begin
                        estado       <= INT_REQ;
                        pb.interrupt <= 1'b1;
                    end
                end
                INT_REQ: begin
                    if (pb.interrupt_ack) begin
                        estado       <= INT_WAIT;
                        pb.interrupt <= 1'b0;
                    end
                end
                INT_WAIT: begin
                    pb.interrupt <= 1'b0;
                    if (!pend_c) begin
                        estado <= INT_IDLE;
                    end
                end
                default: begin
                    estado       <= INT_IDLE;
                    pb.interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_lectura_picoblaze.sv
// Bench for mux_lectura_picoblaze with DEB_CICLOS=4.
// Stimulus pushes expected in_port / interrupt values into queues and raises a
// check flag for that cycle; a monitor on the falling edge pops and compares.
module tb_mux_lectura_picoblaze;

    typedef struct {
        int         id;
        logic [7:0] valor;
    } esperado_t;

    logic       reloj = 1'b0;
    logic       resetM;
    logic       bot_arriba, bot_abajo, bot_izq, bot_der;
    logic       sw_prog, sw_formato;
    logic [7:0] dato_rtc;
    logic       dato_rtc_valid;

    logic       chk_in  = 1'b0;
    logic       chk_int = 1'b0;
    esperado_t  q_in[$];
    esperado_t  q_int[$];
    int         id_in   = 0;
    int         id_int  = 0;
    int         total   = 0;
    int         pasados = 0;
    esperado_t  e_in, e_int;

    mux_lectura_picoblaze_if pb();

    mux_lectura_picoblaze #(
        .DEB_CICLOS (4),
        .DEB_W      (3),
        .INT_EN     (1'b1)
    ) dut (
        .reloj          (reloj),
        .resetM         (resetM),
        .pb             (pb),
        .bot_arriba     (bot_arriba),
        .bot_abajo      (bot_abajo),
        .bot_izq        (bot_izq),
        .bot_der        (bot_der),
        .sw_prog        (sw_prog),
        .sw_formato     (sw_formato),
        .dato_rtc       (dato_rtc),
        .dato_rtc_valid (dato_rtc_valid)
    );

    always #5 reloj = ~reloj;

    // Advance to just after the next rising edge; check flags last one cycle
    task automatic ciclo(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge reloj);
            #1;
            chk_in  = 1'b0;
            chk_int = 1'b0;
        end
    endtask

    task automatic obs_in(input logic [7:0] v);
        esperado_t e;
        e.id    = id_in;
        e.valor = v;
        id_in++;
        q_in.push_back(e);
        chk_in = 1'b1;
    endtask

    task automatic obs_int(input logic v);
        esperado_t e;
        e.id    = id_int;
        e.valor = {7'b0, v};
        id_int++;
        q_int.push_back(e);
        chk_int = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge reloj) begin
        if (chk_in) begin
            total++;
            if (q_in.size() == 0) begin
                $display("FAIL in_port: check with no expected value queued");
            end else begin
                e_in = q_in.pop_front();
                if (pb.in_port === e_in.valor) pasados++;
                else $display("FAIL in_port#%0d: got 0x%02h, expected 0x%02h",
                              e_in.id, pb.in_port, e_in.valor);
            end
        end
        if (chk_int) begin
            total++;
            if (q_int.size() == 0) begin
                $display("FAIL interrupt: check with no expected value queued");
            end else begin
                e_int = q_int.pop_front();
                if (pb.interrupt === e_int.valor[0]) pasados++;
                else $display("FAIL interrupt#%0d: got %b, expected %b",
                              e_int.id, pb.interrupt, e_int.valor[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset held with buttons high and the event port selected
        resetM         = 1'b0;
        bot_arriba     = 1'b1;
        bot_abajo      = 1'b1;
        bot_izq        = 1'b1;
        bot_der        = 1'b1;
        sw_prog        = 1'b1;
        sw_formato     = 1'b1;
        dato_rtc       = 8'hAA;
        dato_rtc_valid = 1'b0;
        pb.port_id       = 8'h02;
        pb.rd_10         = 1'b0;
        pb.interrupt_ack = 1'b0;
        ciclo(2);
        obs_in(8'h00); obs_int(1'b0);
        ciclo();
        bot_arriba = 1'b0; bot_abajo = 1'b0; bot_izq = 1'b0; bot_der = 1'b0;
        sw_prog = 1'b0; sw_formato = 1'b0; dato_rtc = 8'h00;
        resetM = 1'b1;
        ciclo(8);
        obs_in(8'h00); obs_int(1'b0);
        ciclo();

        // Debounced press: ev visible 6 edges after raw rise, interrupt one edge later
        bot_izq = 1'b1;
        ciclo(6);
        obs_in(8'h00); obs_int(1'b0);
        ciclo();
        obs_in(8'h02); obs_int(1'b1);
        ciclo(13);
        bot_izq = 1'b0;
        ciclo(8);
        obs_in(8'h02); obs_int(1'b1);
        ciclo();

        // Ack drops interrupt; FSM now waits for flags to clear
        pb.interrupt_ack = 1'b1;
        ciclo();
        pb.interrupt_ack = 1'b0;
        obs_int(1'b0);

        // Three-cycle glitch is rejected
        bot_der = 1'b1;
        ciclo(3);
        bot_der = 1'b0;
        ciclo(8);
        obs_in(8'h02); obs_int(1'b0);
        ciclo();

        // New event while waiting does not re-raise
        bot_arriba = 1'b1;
        ciclo(10);
        obs_in(8'h0A); obs_int(1'b0);
        ciclo();
        bot_arriba = 1'b0;
        ciclo(8);

        // Read-to-clear of events returns the pre-clear value
        pb.rd_10 = 1'b1;
        obs_in(8'h0A);
        ciclo();
        pb.rd_10 = 1'b0;
        ciclo(2);
        obs_in(8'h00); obs_int(1'b0);
        ciclo();

        // Back in idle: next event raises interrupt again
        bot_arriba = 1'b1;
        ciclo(8);
        obs_in(8'h08); obs_int(1'b1);
        ciclo();
        bot_arriba = 1'b0;
        ciclo(8);

        // Read-clear coincides with the abajo pulse: abajo survives, arriba clears
        bot_abajo = 1'b1;
        ciclo(5);
        pb.rd_10 = 1'b1;
        obs_in(8'h08);
        ciclo();
        pb.rd_10 = 1'b0;
        ciclo();
        obs_in(8'h04); obs_int(1'b1);
        ciclo(8);
        bot_abajo = 1'b0;
        ciclo(8);

        // Switches; a strobed read of another port leaves events alone
        sw_prog = 1'b1; sw_formato = 1'b0;
        pb.port_id = 8'h04;
        ciclo(3);
        pb.rd_10 = 1'b1;
        obs_in(8'h01);
        ciclo();
        pb.rd_10 = 1'b0;
        sw_prog = 1'b0; sw_formato = 1'b1;
        ciclo(3);
        obs_in(8'h02);
        ciclo();
        pb.port_id = 8'h02;
        ciclo();
        obs_in(8'h04);
        ciclo();

        pb.interrupt_ack = 1'b1;
        ciclo();
        pb.interrupt_ack = 1'b0;
        obs_int(1'b0);
        pb.rd_10 = 1'b1;
        obs_in(8'h04);
        ciclo();
        pb.rd_10 = 1'b0;
        ciclo(2);
        obs_in(8'h00); obs_int(1'b0);
        ciclo();

        // RTC: two captures set overflow
        dato_rtc = 8'h59; dato_rtc_valid = 1'b1;
        ciclo();
        dato_rtc = 8'h23;
        ciclo();
        dato_rtc_valid = 1'b0; dato_rtc = 8'hFF;
        obs_int(1'b1);
        pb.port_id = 8'h10;
        ciclo();
        pb.rd_10 = 1'b1;
        obs_in(8'h03);
        ciclo();
        pb.rd_10 = 1'b0;
        pb.port_id = 8'h08;
        ciclo();
        pb.rd_10 = 1'b1;
        obs_in(8'h23);
        ciclo();
        pb.rd_10 = 1'b0;
        pb.port_id = 8'h10;
        ciclo();
        pb.rd_10 = 1'b1;
        obs_in(8'h00);
        ciclo();
        pb.rd_10 = 1'b0;
        pb.interrupt_ack = 1'b1;
        ciclo();
        pb.interrupt_ack = 1'b0;
        obs_int(1'b0);
        ciclo();

        // Strobe in the same cycle as the status read: dato_nuevo set, overflow clear
        dato_rtc = 8'h11; dato_rtc_valid = 1'b1;
        ciclo();
        dato_rtc_valid = 1'b0;
        ciclo();
        pb.rd_10 = 1'b1;
        dato_rtc = 8'h22; dato_rtc_valid = 1'b1;
        obs_in(8'h01);
        ciclo();
        pb.rd_10 = 1'b0; dato_rtc_valid = 1'b0;
        ciclo();
        obs_in(8'h01);
        ciclo();
        pb.port_id = 8'h08;
        ciclo();
        obs_in(8'h22);
        ciclo();

        // Unmapped address reads zero
        pb.port_id = 8'h03;
        ciclo();
        obs_in(8'h00);
        ciclo(2);

        if (q_in.size() != 0 || q_int.size() != 0) begin
            $display("FAIL scoreboard: %0d in_port and %0d interrupt checks never observed",
                     q_in.size(), q_int.size());
            total += q_in.size() + q_int.size();
        end

        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule

// File: doc/mux_lectura_picoblaze.md
Name: mux_lectura_picoblaze

Overview:
- Read-side companion of the PicoBlaze output demux: returns data to PicoBlaze `INPUT` instructions.
- Four front-panel buttons are synchronised and debounced, then captured as sticky read-to-clear event flags.
- Also latches the RTC read-data bus and the mode switches.
- Multiplexes all of these onto a registered `in_port`, and raises an interrupt with an ack handshake when new events are pending.

Parameters:
- `DEB_CICLOS`, 16, consecutive stable cycles a synchronised button level must hold before it is accepted (min 2).
- `DEB_W`, 5, width of each debounce counter; must satisfy 2^`DEB_W` > `DEB_CICLOS`.
- `INT_EN`, 1, when 0 the interrupt output is tied 0 and the FSM stays in `INT_IDLE`.

Ports:
- `reloj`  in  1  system clock, rising-edge.
- `resetM`  in  1  asynchronous reset, active-low.
- `port_id`  in  8  PicoBlaze port address.
- `rd_10`  in  1  PicoBlaze `read_strobe`, one cycle.
- `in_port`  out  8  data returned to PicoBlaze, registered.
- `bot_arriba`, `bot_abajo`, `bot_izq`, `bot_der`  in  1 each  raw asynchronous buttons, active-high.
- `sw_prog`, `sw_formato`  in  1 each  raw asynchronous slide switches.
- `dato_rtc`  in  8  RTC read bus.
- `dato_rtc_valid`  in  1  one-cycle strobe; `dato_rtc` is valid in that cycle.
- `interrupt`  out  1  interrupt request to PicoBlaze.
- `interrupt_ack`  in  1  PicoBlaze `interrupt_ack`, one cycle.

Behaviour:
- Reset (`resetM`=0, asynchronous) clears:
  - `in_port`=0x00, `interrupt`=0;
  - all sync flops, debounce counters, debounced levels, event flags, switch regs, `rtc_reg`, `dato_nuevo`, `overflow`;
  - FSM to `INT_IDLE`.
- Reset mid-transaction discards pending events and pending interrupt. Nothing is restored.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synced level differs from the debounced level, and clears when they match.
  - On reaching `DEB_CICLOS`, the debounced level toggles and the counter clears.
  - A 0→1 transition of the debounced level produces a one-cycle event pulse.
  - Total latency from a clean raw press to pulse = 2 + `DEB_CICLOS` cycles.
- Switches: 2-flop synchroniser only, no debounce.
- Event register `ev[3:0]` = {arriba, abajo, izq, der}:
  - A pulse sets its bit.
  - A read of 0x02 (`rd_10`=1, `port_id`=0x02) clears all bits at the next edge.
  - Same-cycle pulse and clear: that bit ends set (set wins); other bits clear.
- RTC capture:
  - `dato_rtc_valid` loads `rtc_reg`←`dato_rtc` and sets `dato_nuevo`.
  - If `dato_nuevo` was already 1, `overflow` is also set.
  - A read of 0x10 clears `dato_nuevo` and `overflow`; a same-cycle strobe wins and sets `dato_nuevo` again, with `overflow` cleared.
- Read map, decoded on `port_id` every cycle; `in_port` is registered, so the value is visible one cycle after `port_id`:
  - 0x02: {4'b0, `ev`}
  - 0x04: {6'b0, `sw_formato`_s, `sw_prog`_s}
  - 0x08: `rtc_reg`
  - 0x10: {6'b0, `overflow`, `dato_nuevo`}
  - any other address: 0x00
- Read-to-clear acts only when `rd_10`=1. `in_port` in the strobe cycle shows the pre-clear value. `rd_10` on other addresses has no side effect.
- Interrupt FSM; `pend` = (`ev`≠0) | `dato_nuevo`:
  - `INT_IDLE`: `interrupt`=0; go to `INT_REQ` when `pend`.
  - `INT_REQ`: `interrupt`=1; go to `INT_WAIT` on `interrupt_ack`.
  - `INT_WAIT`: `interrupt`=0; go to `INT_IDLE` when `pend`=0. New events arriving here do not re-raise the interrupt until the handler clears every pending flag.
  - `interrupt` is a registered output: it rises one cycle after `pend`, and falls on the edge where `interrupt_ack` is sampled.

Decomposition:
- Shared package `pkg_puertos_picoblaze`:
  - read addresses: `P_EVENTOS`=0x02, `P_SWITCH`=0x04, `P_RTC`=0x08, `P_ESTADO`=0x10;
  - interrupt FSM state encodings (`INT_IDLE`=2'd0, `INT_REQ`=2'd1, `INT_WAIT`=2'd2).
- One sub-module, `antirrebote_flanco`: sync + debounce + rising-edge pulse, parameterised by `DEB_CICLOS`/`DEB_W`, instantiated four times.

Test Plan:
- Reset: hold `resetM`=0 with buttons high and `port_id`=0x02 → `in_port`=0x00, `interrupt`=0. Release with all inputs low → outputs stay 0.
- Debounced press (`DEB_CICLOS`=4): `bot_izq` high 20 cycles → `ev`=0x02 exactly 6 cycles after the rising edge. `interrupt`=1 next cycle.
- Glitch: `bot_der` high 3 cycles then low (`DEB_CICLOS`=4) → no event, `interrupt` stays 0.
- Read-clear race: `ev`=0x08, then `rd_10`@0x02 in the same cycle as an `abajo` pulse → `in_port`=0x08 during the read. Next cycle `ev`=0x04.
- RTC overflow: two `dato_rtc_valid` strobes with 0x59 then 0x23, then read 0x10 → `in_port`=0x03. Read 0x08 → `in_port`=0x23. Re-read 0x10 → 0x00.
- Interrupt handshake: event → `interrupt`=1. Pulse `interrupt_ack` → 0, FSM in `INT_WAIT`. New event → `interrupt` stays 0. Read 0x02 clears `ev` → FSM to `INT_IDLE` → next event raises `interrupt` again.
